// File: rtl/mmio_io_hub.sv
`default_nettype none
// ============================================================================
// Module   : mmio_io_hub
// Purpose  : Memory-mapped I/O hub between the single-cycle MIPS core and the
//            board pins. It provides configurable LED and switch lanes, a
//            debounced check button with a sticky press flag, and a
//            free-running cycle counter. Reads are combinational; writes and
//            side effects commit on the rising clock edge.
// Ports    : clock, rst          - CPU clock, synchronous active-high reset
//            addr, io_read,
//            io_write, wdata     - CPU bus (byte address, strobes, store data)
//            rdata               - combinational load data
//            switches, button    - raw asynchronous board inputs
//            leds, btn_event     - registered LED drive, sticky press flag
// Revision : 1.0 - initial release
// ============================================================================
module mmio_io_hub #(
    parameter int LED_W      = 16,
    parameter int SW_W       = 16,
    parameter int DEB_CYCLES = 200000,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [31:0]      addr,
    input  logic             io_read,
    input  logic             io_write,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [SW_W-1:0]  switches,
    input  logic             button,
    output logic [LED_W-1:0] leds,
    output logic             btn_event
);

    localparam int       c_LED_LANES = LED_W / 8;
    localparam int       c_SW_LANES  = SW_W / 8;
    localparam int       c_DCNT_W    = $clog2(DEB_CYCLES);
    localparam logic [9:0] c_LED_BASE = 10'h060;
    localparam logic [9:0] c_SW_BASE  = 10'h070;
    localparam logic [9:0] c_STATUS   = 10'h080;
    localparam logic [9:0] c_COUNTER  = 10'h084;
    localparam logic [c_DCNT_W-1:0] c_DEB_MAX = c_DCNT_W'(DEB_CYCLES - 1);

    logic [LED_W-1:0]    r_leds;
    logic [LED_W-1:0]    w_leds_next;
    logic [SW_W-1:0]     r_sw_meta;
    logic [SW_W-1:0]     r_sw_sync;
    logic                r_btn_meta;
    logic                r_btn_sync;
    logic                r_stable;
    logic                r_sticky;
    logic [c_DCNT_W-1:0] r_dcnt;
    logic [CNT_W-1:0]    r_count;

    logic       w_hit;
    logic [9:0] w_off;
    logic       w_status_rd;
    logic       w_count_wr;
    logic       w_accept;
    logic       w_rise;
    logic [31:0] w_rdata;
    logic       w_unused_wdata;

    assign w_hit       = (addr[31:10] == 22'h3FFFFF);
    assign w_off       = addr[9:0];
    assign w_status_rd = w_hit && io_read  && (w_off == c_STATUS);
    assign w_count_wr  = w_hit && io_write && (w_off == c_COUNTER);

    // Only the low byte of store data reaches an LED lane.
    assign w_unused_wdata = ^wdata[31:8];

    // A level change is accepted on the edge where the debounce count tops out;
    // the sticky flag is set on that same edge when the new level is high.
    assign w_accept = (r_btn_sync != r_stable) && (r_dcnt == c_DEB_MAX);
    assign w_rise   = w_accept && r_btn_sync;

    always_comb begin
        w_leds_next = r_leds;
        if (w_hit && io_write) begin
            for (int k = 0; k < c_LED_LANES; k++) begin
                if (w_off == 10'(c_LED_BASE + k))
                    w_leds_next[8*k +: 8] = wdata[7:0];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            for (int k = 0; k < c_LED_LANES; k++) begin
                if (w_off == 10'(c_LED_BASE + k))
                    w_rdata[7:0] = r_leds[8*k +: 8];
            end
            for (int k = 0; k < c_SW_LANES; k++) begin
                if (w_off == 10'(c_SW_BASE + k))
                    w_rdata[7:0] = r_sw_sync[8*k +: 8];
            end
            if (w_off == c_STATUS)
                w_rdata[1:0] = {r_sticky, r_stable};
            if (w_off == c_COUNTER)
                w_rdata[CNT_W-1:0] = r_count;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_leds     <= '0;
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
            r_stable   <= 1'b0;
            r_sticky   <= 1'b0;
            r_dcnt     <= '0;
            r_count    <= '0;
        end else begin
            r_leds     <= w_leds_next;
            r_sw_meta  <= switches;
            r_sw_sync  <= r_sw_meta;
            r_btn_meta <= button;
            r_btn_sync <= r_btn_meta;

            if (r_btn_sync == r_stable) begin
                r_dcnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_btn_sync;
                r_dcnt   <= '0;
            end else begin
                r_dcnt <= r_dcnt + c_DCNT_W'(1);
            end

            // Setting beats a same-cycle status-load clear.
            if (w_rise)
                r_sticky <= 1'b1;
            else if (w_status_rd)
                r_sticky <= 1'b0;

            // A store wins over the increment, so the count lands on 0.
            if (w_count_wr)
                r_count <= '0;
            else
                r_count <= r_count + CNT_W'(1);
        end
    end

    assign rdata     = w_rdata;
    assign leds      = r_leds;
    assign btn_event = r_sticky;

endmodule
`default_nettype wire
